// File: rtl/numlock_code_sender.sv
// Presses U/Z for each code bit (MSB first), tick-paced press and gap; done pulses one clk after the last gap, start ignored while busy.
// Outputs registered (one edge after the state decision); optional NUMLOCK_SENDER_COUNT_EN adds a saturating sent_count.
module numlock_code_sender #(
  parameter int CODE_LEN    = 4,
  parameter int PRESS_TICKS = 2,
  parameter int GAP_TICKS   = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic                abort,
  output logic                U,
  output logic                Z,
  output logic                busy,
  output logic                done,
`ifdef NUMLOCK_SENDER_COUNT_EN
  output logic [2:0]          bit_idx,
  output logic [7:0]          sent_count
`else
  output logic [2:0]          bit_idx
`endif
);

  localparam int MAX_TICKS = (PRESS_TICKS > GAP_TICKS) ? PRESS_TICKS : GAP_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);
  localparam logic [2:0]       IDX_TOP    = 3'(CODE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CODE_LEN-1:0] r_shift;
  logic [CODE_LEN-1:0] w_shift_nxt;
  logic [2:0]          r_bit_idx;
  logic [2:0]          w_bit_idx_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_u;
  logic                r_z;
  logic                r_busy;
  logic                r_done;
  logic                w_u_nxt;
  logic                w_z_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_press_end;
  logic                w_gap_end;

  assign w_press_end = (r_state == S_PRESS) && tick && (r_cnt == PRESS_LAST);
  assign w_gap_end   = (r_state == S_GAP) && tick && (r_cnt == GAP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= 3'd0;
      r_cnt     <= '0;
      r_u       <= 1'b0;
      r_z       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_u       <= w_u_nxt;
      r_z       <= w_z_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_PRESS;
      end
      S_PRESS: begin
        if (abort)            w_state_nxt = S_IDLE;
        else if (w_press_end) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (abort)          w_state_nxt = S_IDLE;
        else if (w_gap_end) w_state_nxt = (r_bit_idx == 3'd0) ? S_DONE : S_PRESS;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath next values plus the registered button drives, all derived from the next state.
  always_comb begin
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shift_nxt   = code;
          w_bit_idx_nxt = IDX_TOP;
          w_cnt_nxt     = '0;
        end
      end
      S_PRESS: begin
        if (abort) begin
          w_shift_nxt   = '0;
          w_bit_idx_nxt = 3'd0;
          w_cnt_nxt     = '0;
        end else if (tick) begin
          w_cnt_nxt = w_press_end ? '0 : r_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          w_shift_nxt   = '0;
          w_bit_idx_nxt = 3'd0;
          w_cnt_nxt     = '0;
        end else if (w_gap_end) begin
          w_cnt_nxt = '0;
          if (r_bit_idx != 3'd0) begin
            w_bit_idx_nxt = r_bit_idx - 3'd1;
            w_shift_nxt   = r_shift << 1;
          end
        end else if (tick) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase

    w_u_nxt    = (w_state_nxt == S_PRESS) &&  w_shift_nxt[CODE_LEN-1];
    w_z_nxt    = (w_state_nxt == S_PRESS) && !w_shift_nxt[CODE_LEN-1];
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign U       = r_u;
  assign Z       = r_z;
  assign busy    = r_busy;
  assign done    = r_done;
  assign bit_idx = r_bit_idx;

`ifdef NUMLOCK_SENDER_COUNT_EN
  logic [7:0] r_sent_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sent_count <= 8'd0;
    end else if (w_done_nxt && (r_sent_count != 8'hFF)) begin
      r_sent_count <= r_sent_count + 8'd1;
    end
  end

  assign sent_count = r_sent_count;
`endif

endmodule

// File: tb/tb_numlock_code_sender.sv
// Bench for numlock_code_sender: vector table, directed corner cases and a tick-count reference model.
module tb_numlock_code_sender;

  localparam int L    = 4;
  localparam int P    = 2;
  localparam int G    = 2;
  localparam int MAXC = 256;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic       tick    = 1'b0;
  logic       start   = 1'b0;
  logic       abort   = 1'b0;
  logic [3:0] code    = 4'd0;
  logic       U, Z, busy, done;
  logic [2:0] bit_idx;
`ifdef NUMLOCK_SENDER_COUNT_EN
  logic [7:0] sent_count;
`endif

  int n_pass = 0;
  int n_chk  = 0;
  int tk    [MAXC];
  int e_out [MAXC];
  int done_at;

  typedef struct {
    logic [3:0] code;
    int         period;
    int         total;
    int         u_press;
    int         z_press;
    int         seg_len;
  } vec_t;

  vec_t vecs [5];

  numlock_code_sender dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .start   (start),
    .code    (code),
    .abort   (abort),
    .U       (U),
    .Z       (Z),
    .busy    (busy),
    .done    (done),
`ifdef NUMLOCK_SENDER_COUNT_EN
    .bit_idx    (bit_idx),
    .sent_count (sent_count)
`else
    .bit_idx (bit_idx)
`endif
  );

  always #5 clk = ~clk;

  // {U,Z,busy,done,bit_idx} as one integer
  function automatic int outs();
    return (int'(U) << 6) | (int'(Z) << 5) | (int'(busy) << 4) | (int'(done) << 3) | int'(bit_idx);
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, want);
  endtask

  // Expected outputs per cycle after the accept edge, from counting ticks per segment.
  task automatic build_exp(input logic [3:0] c);
    int k, need, seen, b;
    bit pr;
    k = 0;
    for (int s = 0; s < 2 * L; s++) begin
      pr   = (s % 2 == 0);
      need = pr ? P : G;
      b    = L - 1 - s / 2;
      seen = 0;
      while (seen < need) begin
        e_out[k] = ((pr && c[b]) ? 64 : 0) | ((pr && !c[b]) ? 32 : 0) | 16 | b;
        if (tk[k] != 0) seen++;
        k++;
      end
    end
    e_out[k]     = 16 | 8;
    done_at      = k;
    e_out[k + 1] = 0;
    e_out[k + 2] = 0;
  endtask

  task automatic run_model(input logic [3:0] c, input bit chaos);
    for (int k = 0; k < MAXC; k++) tk[k] = (k >= 200) ? 1 : int'($urandom_range(0, 1));
    build_exp(c);
    @(negedge clk);
    code  = c;
    start = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= done_at + 2; k++) begin
      chk($sformatf("model_c%0d", k), outs(), e_out[k]);
      tick = (tk[k] != 0);
      if (chaos && k < done_at) begin
        start = 1'($urandom_range(0, 1));
        code  = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int run, bad, over, nu, nz, total;
    bit last_u;
    run = 0; bad = 0; over = 0; nu = 0; nz = 0; total = -1; last_u = 1'b0;
    @(negedge clk);
    code  = v.code;
    start = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (U && Z) over++;
      if (U || Z) begin
        run++;
        last_u = U;
      end else if (run > 0) begin
        if (run != v.seg_len) bad++;
        if (last_u) nu++;
        else        nz++;
        run = 0;
      end
      if (done) begin
        total = k + 1;
        break;
      end
      tick = ((k % v.period) == v.period - 1);
      @(negedge clk);
    end
    chk($sformatf("vec%0d_total", idx), total, v.total);
    chk($sformatf("vec%0d_u_presses", idx), nu, v.u_press);
    chk($sformatf("vec%0d_z_presses", idx), nz, v.z_press);
    chk($sformatf("vec%0d_bad_len", idx), bad, 0);
    chk($sformatf("vec%0d_uz_overlap", idx), over, 0);
  endtask

  task automatic run_fast(output bit ok);
    ok = 1'b0;
    @(negedge clk);
    code  = 4'($urandom);
    start = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", outs(), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset", outs(), 0);

    vecs[0] = '{4'b1011, 1, 17, 3, 1, 2};
    vecs[1] = '{4'b0000, 4, 65, 0, 4, 8};
    vecs[2] = '{4'b1111, 1, 17, 4, 0, 2};
    vecs[3] = '{4'b0110, 2, 33, 2, 2, 4};
    vecs[4] = '{4'b1000, 3, 49, 1, 3, 6};
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // abort during the gap of bit 1
    @(negedge clk);
    code  = 4'b1011;
    start = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_pre_gap", outs(), 16 | 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", outs() >> 3, 0);
    repeat (5) begin
      @(negedge clk);
      chk("abort_quiet", outs() >> 3, 0);
    end
    run_model(4'b1011, 1'b0);

    // asynchronous reset in the middle of a press
    @(negedge clk);
    code  = 4'b1111;
    start = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_pre_press", outs() >> 3, 4'b1010);
    #1 reset_n = 1'b0;
    #1 chk("rst_async", outs(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_quiet", outs(), 0);
    end

    // start held high through DONE is taken in the following idle cycle
    @(negedge clk);
    code  = 4'b0101;
    start = 1'b1;
    tick  = 1'b1;
    repeat (17) @(negedge clk);
    chk("held_done", outs() >> 3, 4'b0011);
    @(negedge clk);
    chk("held_idle", outs() >> 3, 0);
    @(negedge clk);
    chk("held_restart", outs(), 32 | 16 | 3);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("held_abort", outs() >> 3, 0);

    for (int i = 0; i < 20; i++) run_model(4'($urandom), (i % 2) == 1);

`ifdef NUMLOCK_SENDER_COUNT_EN
    begin
      bit ok;
      int n_to;
      n_to = 0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("cnt_reset", int'(sent_count), 0);
      repeat (3) begin
        run_fast(ok);
        if (!ok) n_to++;
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      chk("cnt_three", int'(sent_count), 3);
      repeat (300) begin
        run_fast(ok);
        if (!ok) n_to++;
      end
      @(negedge clk);
      chk("cnt_sat", int'(sent_count), 255);
      chk("cnt_timeouts", n_to, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/numlock_code_sender.md
NUMLOCK_CODE_SENDER -- requirements
Module: numlock_code_sender

Interface
REQ-001 Parameter CODE_LEN, default 4: number of code bits sent per sequence (range 1..8).
REQ-002 Parameter PRESS_TICKS, default 2: number of tick pulses each button press is held.
REQ-003 Parameter GAP_TICKS, default 2: number of tick pulses both buttons are released between presses.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1: reset, asynchronous assert and active-low.
REQ-006 tick  input  1: one-clk-wide pacing enable; press and gap timing counts only cycles with tick=1.
REQ-007 start  input  1: sequence request; sampled in IDLE only.
REQ-008 code  input  CODE_LEN: combination to send, MSB first; captured on the accepted start.
REQ-009 abort  input  1: synchronous cancel of the sequence in progress.
REQ-010 U  output  1: "one" button drive, registered.
REQ-011 Z  output  1: "zero" button drive, registered.
REQ-012 busy  output  1: high in every state except IDLE.
REQ-013 done  output  1: one-clk pulse when the last release gap completes.
REQ-014 bit_idx  output  3: index of the bit currently being sent.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, PRESS, GAP, DONE.
REQ-016 In IDLE, start=1 SHALL latch code into a shift register, set bit_idx=CODE_LEN-1, clear the tick counter, and enter PRESS on the next edge.
REQ-017 In PRESS, U SHALL equal the current code bit and Z SHALL equal its inverse; U and Z SHALL never be 1 together.
REQ-018 PRESS SHALL advance to GAP on the clk edge where tick=1 and the counter equals PRESS_TICKS-1; the counter SHALL then clear.
REQ-019 In GAP, U=Z=0; GAP SHALL exit on the edge where tick=1 and the counter equals GAP_TICKS-1.
REQ-020 On GAP exit, if bit_idx=0 the FSM SHALL enter DONE; otherwise it SHALL decrement bit_idx and re-enter PRESS.
REQ-021 DONE SHALL last exactly one clk with done=1, then return to IDLE unconditionally.
REQ-022 start SHALL be ignored while busy=1; a start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with U=Z=0 and no done pulse; abort has priority over tick and start.
REQ-024 Changes to code after acceptance SHALL NOT affect the sequence in progress.
REQ-025 With tick held at 1, one bit SHALL take PRESS_TICKS+GAP_TICKS clk cycles; the total from accepted start to done is 1+CODE_LEN*(PRESS_TICKS+GAP_TICKS) cycles.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, with U=0, Z=0, busy=0, done=0, bit_idx=0, tick counter=0 and the shift register cleared.
REQ-027 Reset mid-sequence SHALL discard the sequence; after reset_n rises, no output changes until a new start.

Configuration
REQ-028 Macro NUMLOCK_SENDER_COUNT_EN: when defined, the block SHALL add output sent_count (8 bits), which resets to 0, increments on each done pulse, saturates at 255, and does not count aborted sequences.
REQ-029 When NUMLOCK_SENDER_COUNT_EN is undefined, sent_count and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Use defaults with tick=1 and code=4'b1011, then pulse start: U/Z pattern is U,gap,Z,gap,U,gap,U,gap with 2 cycles per segment; done occurs 17 cycles after the start edge.
REQ-031 Set tick=1 every 4th cycle with code=4'b0000: each Z press lasts 8 clk; 4 Z pulses are produced with U never high.
REQ-032 Pulse start again during PRESS of bit 2, and change code mid-sequence: the second start and the code change are ignored, and the original sequence completes unchanged.
REQ-033 Assert abort for one clk during GAP of bit 1: the next cycle is IDLE, with U=Z=0, busy=0 and no done pulse; a new start then sends the full code.
REQ-034 Drive reset_n=0 asynchronously mid-PRESS: U, Z and busy drop without waiting for a clk edge, and stay idle after release.
REQ-035 With NUMLOCK_SENDER_COUNT_EN defined, run 3 completed sequences and 1 aborted sequence: sent_count=3; forcing 300 completions gives sent_count=255.
